// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - shares one fixed-latency memory between LC3 fetch and data ports; LC3_ARB_RR_EN selects round-robin tie-break
module lc3_mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          instrmem_rd,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] Instr_dout,
    output logic          complete_instr,
    input  logic          data_req,
    input  logic          Data_rd,
    input  logic [AW-1:0] Data_addr,
    input  logic [DW-1:0] Data_dout,
    output logic [DW-1:0] Data_din,
    output logic          complete_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Counter reload value; MEM_LAT is limited to 1..4 so two bits suffice.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          gnt_data_q, gnt_data_d;   // 1: access in flight belongs to the data port
    logic          we_q, we_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] din_q, din_d;
    logic          tie_pick_data;
    logic          grant_data;

`ifdef LC3_ARB_RR_EN
    logic last_data_q;

    // Remember which port won the latest grant; reset favours instruction on the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_data_q <= 1'b1;
        end else if (state_q == IDLE && (instrmem_rd || data_req)) begin
            last_data_q <= grant_data;
        end
    end

    assign tie_pick_data = ~last_data_q;
`else
    assign tie_pick_data = 1'b1;
`endif

    // A lone request always wins; on a tie the policy above decides.
    assign grant_data = data_req & (~instrmem_rd | tie_pick_data);

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_data_q <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            instr_q    <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            instr_q    <= instr_d;
            din_q      <= din_d;
        end
    end

    // Next-state logic: latch the winning request in IDLE, count latency in WAIT, capture read data at the end.
    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        instr_d    = instr_q;
        din_d      = din_q;
        case (state_q)
            IDLE: begin
                if (instrmem_rd || data_req) begin
                    gnt_data_d = grant_data;
                    addr_d     = grant_data ? Data_addr : pc;
                    we_d       = grant_data & ~Data_rd;
                    if (grant_data) begin
                        wdata_d = Data_dout;
                    end
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (!gnt_data_q) begin
                        instr_d = mem_rdata;
                    end else if (!we_q) begin
                        din_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_en         = (state_q == ISSUE);
    assign mem_we         = mem_en & we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign Instr_dout     = instr_q;
    assign Data_din       = din_q;
    assign complete_instr = (state_q == RESP) & ~gnt_data_q;
    assign complete_data  = (state_q == RESP) & gnt_data_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - randomized self-checking bench for lc3_mem_arbiter (lane 0 MEM_LAT=1, lane 1 MEM_LAT=3)
module tb_lc3_mem_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset          [2];
    logic        instrmem_rd    [2];
    logic [15:0] pc             [2];
    logic [15:0] Instr_dout     [2];
    logic        complete_instr [2];
    logic        data_req       [2];
    logic        Data_rd        [2];
    logic [15:0] Data_addr      [2];
    logic [15:0] Data_dout      [2];
    logic [15:0] Data_din       [2];
    logic        complete_data  [2];
    logic        mem_en         [2];
    logic        mem_we         [2];
    logic [15:0] mem_addr       [2];
    logic [15:0] mem_wdata      [2];
    logic [15:0] mem_rdata      [2];
    logic        busy           [2];

    for (genvar g = 0; g < 2; g++) begin : lane
        lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT((g == 0) ? 1 : 3)) dut (
            .clock(clock), .reset(reset[g]),
            .instrmem_rd(instrmem_rd[g]), .pc(pc[g]), .Instr_dout(Instr_dout[g]),
            .complete_instr(complete_instr[g]),
            .data_req(data_req[g]), .Data_rd(Data_rd[g]), .Data_addr(Data_addr[g]),
            .Data_dout(Data_dout[g]), .Data_din(Data_din[g]), .complete_data(complete_data[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    // Memory image: untouched words hold a fixed pattern, 3000 holds 1234.
    function automatic logic [15:0] dflt(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5C3);
    endfunction

    // Memory device per lane: read data is valid only in cycle issue+MEM_LAT, garbage otherwise.
    logic [15:0] dev_mem [int];
    int          cyc = 0;
    int          ready  [2] = '{-1, -1};
    logic [15:0] rd_val [2] = '{16'h0, 16'h0};
    int          dk;
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            dk = g * 65536 + int'(mem_addr[g]);
            if (mem_en[g]) begin
                if (mem_we[g]) begin
                    dev_mem[dk] = mem_wdata[g];
                end else begin
                    rd_val[g] = dev_mem.exists(dk) ? dev_mem[dk] : dflt(mem_addr[g]);
                    ready[g]  = cyc + ((g == 0) ? 1 : 3);
                end
            end
            mem_rdata[g] = (cyc == ready[g]) ? rd_val[g] : ~rd_val[g];
        end
        cyc = cyc + 1;
    end

    // Reference model state.
    logic [15:0] ref_mem [int];
    bit          rr_last_data [2];
    logic [15:0] exp_instr    [2];
    logic [15:0] exp_din      [2];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] ref_rd(input int ln, input logic [15:0] a);
        int k;
        k = ln * 65536 + int'(a);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int ln);
        rr_last_data[ln] = 1'b1;
        exp_instr[ln]    = 16'h0;
        exp_din[ln]      = 16'h0;
    endtask

    task automatic check_zero(input int ln, input string tag);
        check($sformatf("L%0d %s Instr_dout", ln, tag), Instr_dout[ln], 0);
        check($sformatf("L%0d %s Data_din", ln, tag), Data_din[ln], 0);
        check($sformatf("L%0d %s complete_instr", ln, tag), complete_instr[ln], 0);
        check($sformatf("L%0d %s complete_data", ln, tag), complete_data[ln], 0);
        check($sformatf("L%0d %s mem_en", ln, tag), mem_en[ln], 0);
        check($sformatf("L%0d %s mem_we", ln, tag), mem_we[ln], 0);
        check($sformatf("L%0d %s mem_addr", ln, tag), mem_addr[ln], 0);
        check($sformatf("L%0d %s mem_wdata", ln, tag), mem_wdata[ln], 0);
        check($sformatf("L%0d %s busy", ln, tag), busy[ln], 0);
    endtask

    // Requests rise together in cycle 0 (the current negedge); each access takes 3+MEM_LAT cycles
    // including the IDLE cycle that follows its complete pulse.
    task automatic scenario(input int ln, input bit want_i, input bit want_d, input bit ld,
                            input logic [15:0] a_pc, input logic [15:0] a_da, input logic [15:0] wd);
        int lat, n, t1, t2, iss2, t_i, t_d, last, k, slot;
        bit first_data, is_d, exp_en, exp_busy;
        logic [15:0] s_addr [2];
        bit          s_we   [2];
        lat = (ln == 0) ? 1 : 3;
        n   = int'(want_i) + int'(want_d);
        if (want_i && want_d) begin
`ifdef LC3_ARB_RR_EN
            first_data = !rr_last_data[ln];
`else
            first_data = 1'b1;
`endif
        end else begin
            first_data = want_d;
        end
        t1   = 2 + lat;
        iss2 = t1 + 2;
        t2   = t1 + 3 + lat;
        t_d  = !want_d ? -1 : (first_data ? t1 : t2);
        t_i  = !want_i ? -1 : (first_data ? t2 : t1);
        last = (n == 2) ? t2 : t1;
        for (int s = 0; s < n; s++) begin
            is_d      = (s == 0) ? first_data : !first_data;
            s_addr[s] = is_d ? a_da : a_pc;
            s_we[s]   = is_d && !ld;
            if (!is_d) begin
                exp_instr[ln] = ref_rd(ln, a_pc);
            end else if (ld) begin
                exp_din[ln] = ref_rd(ln, a_da);
            end else begin
                k = ln * 65536 + int'(a_da);
                ref_mem[k] = wd;
            end
        end
        rr_last_data[ln] = (n == 2) ? !first_data : want_d;

        instrmem_rd[ln] = want_i;
        pc[ln]          = a_pc;
        data_req[ln]    = want_d;
        Data_rd[ln]     = ld;
        Data_addr[ln]   = a_da;
        Data_dout[ln]   = wd;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clock);
            exp_en   = (c == 1) || (n == 2 && c == iss2);
            exp_busy = (c <= t1) || (n == 2 && c >= iss2 && c <= t2);
            check($sformatf("L%0d c%0d complete_instr", ln, c), complete_instr[ln], c == t_i);
            check($sformatf("L%0d c%0d complete_data", ln, c), complete_data[ln], c == t_d);
            check($sformatf("L%0d c%0d busy", ln, c), busy[ln], exp_busy);
            check($sformatf("L%0d c%0d mem_en", ln, c), mem_en[ln], exp_en);
            if (exp_en) begin
                slot = (c == 1) ? 0 : 1;
                check($sformatf("L%0d c%0d mem_addr", ln, c), mem_addr[ln], s_addr[slot]);
                check($sformatf("L%0d c%0d mem_we", ln, c), mem_we[ln], s_we[slot]);
                if (s_we[slot]) check($sformatf("L%0d c%0d mem_wdata", ln, c), mem_wdata[ln], wd);
            end
            if (c == t_i) begin
                check($sformatf("L%0d c%0d Instr_dout", ln, c), Instr_dout[ln], exp_instr[ln]);
                instrmem_rd[ln] = 1'b0;
            end
            if (c == t_d) begin
                check($sformatf("L%0d c%0d Data_din", ln, c), Data_din[ln], exp_din[ln]);
                data_req[ln] = 1'b0;
            end
            if (c == 2) begin
                if (first_data) begin
                    Data_addr[ln] = 16'($urandom);
                    Data_dout[ln] = 16'($urandom);
                    Data_rd[ln]   = 1'($urandom);
                end else begin
                    pc[ln] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic mid_wait_reset(input int ln);
        instrmem_rd[ln] = 1'b1;
        pc[ln]          = 16'h3000;
        @(negedge clock);
        check($sformatf("L%0d rst issue mem_en", ln), mem_en[ln], 1);
        @(negedge clock);
        check($sformatf("L%0d rst wait busy", ln), busy[ln], 1);
        reset[ln]       = 1'b1;
        instrmem_rd[ln] = 1'b0;
        @(negedge clock);
        check_zero(ln, "after mid reset");
        reset[ln] = 1'b0;
        model_reset(ln);
        repeat (4) begin
            @(negedge clock);
            check($sformatf("L%0d post reset complete_instr", ln), complete_instr[ln], 0);
            check($sformatf("L%0d post reset busy", ln), busy[ln], 0);
        end
        scenario(ln, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h0, 16'h0);
        check($sformatf("L%0d post reset fetch", ln), Instr_dout[ln], 16'h1234);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind;
        for (int g = 0; g < 2; g++) begin
            reset[g] = 1'b1; instrmem_rd[g] = 1'b0; pc[g] = 16'h0; data_req[g] = 1'b0;
            Data_rd[g] = 1'b0; Data_addr[g] = 16'h0; Data_dout[g] = 16'h0;
        end
        repeat (3) @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            check_zero(g, "reset");
            reset[g] = 1'b0;
            model_reset(g);
        end
        @(negedge clock);

        // Directed: fetch, store, tie, second tie, MEM_LAT=3 load.
        scenario(0, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h0, 16'h0);
        check("dir fetch Instr_dout", Instr_dout[0], 16'h1234);
        scenario(0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h4000, 16'hBEEF);
        check("dir store memory", dev_mem[16'h4000], 16'hBEEF);
        check("dir store Data_din", Data_din[0], 16'h0);
        scenario(0, 1'b1, 1'b1, 1'b1, 16'h3000, 16'h4000, 16'h0);
        check("dir tie Data_din", Data_din[0], 16'hBEEF);
        check("dir tie Instr_dout", Instr_dout[0], 16'h1234);
        scenario(0, 1'b1, 1'b1, 1'b1, 16'h3001, 16'h4000, 16'h0);
        scenario(1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h5000, 16'h0);
        check("dir lat3 Data_din", Data_din[1], 16'h5000 ^ 16'hA5C3);

        mid_wait_reset(0);
        mid_wait_reset(1);

        // Randomized traffic over a small address pool so stores and loads collide.
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 30; i++) begin
                kind = $urandom_range(0, 2);
                scenario(g, kind != 1, kind != 0, 1'($urandom),
                         16'h3000 + 16'($urandom_range(0, 15)),
                         16'h3000 + 16'($urandom_range(0, 15)), 16'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
